// File: rtl/dmem_lsu.sv
// Load/store unit for a word-addressed data memory: RV32I lane extraction on loads
// and read-modify-write for sub-word stores. `define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module dmem_lsu (
  input  logic        clkin,
  input  logic        nrst_in,
  input  logic        req_valid_in,
  output logic        req_ready_out,
  input  logic        req_we_in,
  input  logic [2:0]  req_funct3_in,
  input  logic [31:0] req_addr_in,
  input  logic [31:0] req_wdata_in,
  output logic        resp_valid_out,
  output logic [31:0] resp_rdata_out,
  output logic        resp_err_out,
  output logic        wr_en_out,
  output logic [31:0] wr_addr_out,
  output logic [31:0] wr_data_out,
  output logic [31:0] rd_addr_out,
  input  logic [31:0] rd_data_in
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_RMW_READ = 3'd2;
  localparam logic [2:0] S_WRITE    = 3'd3;
  localparam logic [2:0] S_RESP     = 3'd4;

  logic [2:0]  r_state;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_f3_bad;
  logic        w_misalign;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_merge_data;

  // Decode on the live request so the error path can go straight to RESP.
  always_comb begin
    w_f3_bad = (req_funct3_in == 3'b011) || (req_funct3_in == 3'b110) ||
               (req_funct3_in == 3'b111) || (req_we_in && req_funct3_in[2]);
`ifdef LSU_MISALIGN_TRAP_EN
    w_misalign = ((req_funct3_in[1:0] == 2'b01) && req_addr_in[0]) ||
                 ((req_funct3_in[1:0] == 2'b10) && (req_addr_in[1:0] != 2'b00));
`else
    w_misalign = 1'b0;
`endif
  end

  // Halfword lanes select on addr[1] only and words ignore addr[1:0], which gives
  // natural alignment for free when misaligned accesses are not trapped.
  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_byte = rd_data_in[7:0];
      2'd1:    w_byte = rd_data_in[15:8];
      2'd2:    w_byte = rd_data_in[23:16];
      default: w_byte = rd_data_in[31:24];
    endcase
    w_half = r_addr[1] ? rd_data_in[31:16] : rd_data_in[15:0];
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_data = {24'd0, w_byte};
      3'b101:  w_load_data = {16'd0, w_half};
      default: w_load_data = rd_data_in;
    endcase
  end

  always_comb begin
    w_merge_data = rd_data_in;
    if (r_funct3[1:0] == 2'b00) begin
      case (r_addr[1:0])
        2'd0:    w_merge_data[7:0]   = r_wdata[7:0];
        2'd1:    w_merge_data[15:8]  = r_wdata[7:0];
        2'd2:    w_merge_data[23:16] = r_wdata[7:0];
        default: w_merge_data[31:24] = r_wdata[7:0];
      endcase
    end else if (r_addr[1]) begin
      w_merge_data[31:16] = r_wdata[15:0];
    end else begin
      w_merge_data[15:0] = r_wdata[15:0];
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples the
  // pre-edge values; blocking here would let later statements see updated state.
  always_ff @(posedge clkin) begin
    if (!nrst_in) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid_in) begin
            r_we     <= req_we_in;
            r_funct3 <= req_funct3_in;
            r_addr   <= req_addr_in;
            r_wdata  <= req_wdata_in;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
            if (w_f3_bad || w_misalign) begin
              r_err   <= 1'b1;
              r_state <= S_RESP;
            end else if (!req_we_in) begin
              r_state <= S_LOAD;
            end else if (req_funct3_in[1:0] == 2'b10) begin
              r_state <= S_WRITE;
            end else begin
              r_state <= S_RMW_READ;
            end
          end
        end
        S_LOAD: begin
          r_rdata <= w_load_data;
          r_state <= S_RESP;
        end
        S_RMW_READ: begin
          r_wdata <= w_merge_data;
          r_state <= S_WRITE;
        end
        S_WRITE: r_state <= S_RESP;
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Gating with nrst_in keeps a reset asserted mid-access from leaking a write or response.
  assign req_ready_out  = (r_state == S_IDLE);
  assign resp_valid_out = (r_state == S_RESP) && nrst_in;
  assign resp_rdata_out = r_rdata;
  assign resp_err_out   = r_err;
  assign wr_en_out      = (r_state == S_WRITE) && nrst_in;
  assign wr_data_out    = r_wdata;
  assign wr_addr_out    = {2'b00, r_addr[31:2]};
  assign rd_addr_out    = {2'b00, r_addr[31:2]};

  logic w_unused;
  assign w_unused = r_we;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: a byte-lane reference model predicts each response
// and memory write; a monitor compares whatever the DUT presents.
module tb_dmem_lsu;

  logic        clkin = 1'b0;
  logic        nrst_in;
  logic        req_valid_in;
  logic        req_ready_out;
  logic        req_we_in;
  logic [2:0]  req_funct3_in;
  logic [31:0] req_addr_in;
  logic [31:0] req_wdata_in;
  logic        resp_valid_out;
  logic [31:0] resp_rdata_out;
  logic        resp_err_out;
  logic        wr_en_out;
  logic [31:0] wr_addr_out;
  logic [31:0] wr_data_out;
  logic [31:0] rd_addr_out;
  logic [31:0] rd_data_in;

  dmem_lsu dut (
    .clkin(clkin), .nrst_in(nrst_in),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .req_we_in(req_we_in), .req_funct3_in(req_funct3_in),
    .req_addr_in(req_addr_in), .req_wdata_in(req_wdata_in),
    .resp_valid_out(resp_valid_out), .resp_rdata_out(resp_rdata_out),
    .resp_err_out(resp_err_out), .wr_en_out(wr_en_out),
    .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out),
    .rd_addr_out(rd_addr_out), .rd_data_in(rd_data_in)
  );

  always #5 clkin = ~clkin;

  // Memory seen by the DUT; combinational read, clocked write.
  logic [31:0] dmem [0:63];
  assign rd_data_in = dmem[rd_addr_out[5:0]];
  always @(posedge clkin) if (wr_en_out) dmem[wr_addr_out[5:0]] <= wr_data_out;

  int cyc = 0;
  always @(posedge clkin) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct { logic err; logic [31:0] rdata; int cyc; } resp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } wr_t;
  resp_t resp_q[$];
  wr_t   wr_q[$];

  // Reference model's own copy of memory.
  logic [31:0] ref_mem [0:63];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Predict the outcome of an accepted request; acc is the cycle number of cycle 1.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int acc);
    resp_t r;
    wr_t   w;
    logic  bad, mis;
    int    idx, sh, nbytes;
    logic [31:0] word, mask, val;
    bad = (f3 == 3) || (f3 == 6) || (f3 == 7) || (we && f3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
    mis = ((f3[1:0] == 1) && (addr % 2 != 0)) || ((f3[1:0] == 2) && (addr % 4 != 0));
`else
    mis = 1'b0;
`endif
    idx    = int'(addr / 4) % 64;
    word   = ref_mem[idx];
    nbytes = (f3[1:0] == 0) ? 1 : (f3[1:0] == 1) ? 2 : 4;
    sh     = 8 * (int'(addr % 4) / nbytes * nbytes);
    mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 1);
    r.err = 1'b0; r.rdata = 32'd0;
    if (bad || mis) begin
      r.err = 1'b1;
      r.cyc = acc;
    end else if (!we) begin
      val = (word >> sh) & mask;
      if (!f3[2] && nbytes < 4 && val[8 * nbytes - 1]) val = val | ~mask;
      r.rdata = val;
      r.cyc   = acc + 1;
    end else begin
      w.addr = idx;
      w.data = (word & ~(mask << sh)) | ((wdata & mask) << sh);
      w.cyc  = (nbytes == 4) ? acc : acc + 1;
      r.cyc  = w.cyc + 1;
      ref_mem[idx] = w.data;
      wr_q.push_back(w);
    end
    resp_q.push_back(r);
  endtask

  // Called at a negedge; returns at the negedge of cycle 1.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    int guard = 0;
    int acc;
    while (!req_ready_out && guard < 20) begin
      @(negedge clkin);
      guard++;
    end
    check("ready_wait", {31'd0, req_ready_out}, 32'd1);
    req_valid_in = 1'b1; req_we_in = we; req_funct3_in = f3;
    req_addr_in = addr; req_wdata_in = wdata;
    @(posedge clkin);
    #1;
    acc = cyc;
    req_valid_in = 1'b0;
    req_we_in = 1'($urandom); req_funct3_in = 3'($urandom);
    req_addr_in = $urandom; req_wdata_in = $urandom;
    model(we, f3, addr, wdata, acc);
    @(negedge clkin);
  endtask

  // Monitor: every response and every write must match the head of its queue.
  always @(negedge clkin) begin
    if (resp_valid_out) begin
      if (resp_q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        resp_t e;
        e = resp_q.pop_front();
        check("resp_cycle", cyc, e.cyc);
        check("resp_err", {31'd0, resp_err_out}, {31'd0, e.err});
        check("resp_rdata", resp_rdata_out, e.rdata);
      end
    end
    if (wr_en_out) begin
      if (wr_q.size() == 0) begin
        check("unexpected_write", wr_addr_out, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        check("wr_cycle", cyc, e.cyc);
        check("wr_addr", wr_addr_out, e.addr);
        check("wr_data", wr_data_out, e.data);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    logic [31:0] saved;
    for (int i = 0; i < 64; i++) begin
      dmem[i] = $urandom;
      ref_mem[i] = dmem[i];
    end
    dmem[1] = 32'h8070_60F0;
    ref_mem[1] = 32'h8070_60F0;
    nrst_in = 1'b0; req_valid_in = 1'b0; req_we_in = 1'b0;
    req_funct3_in = 3'd0; req_addr_in = 32'd0; req_wdata_in = 32'd0;
    repeat (3) @(negedge clkin);
    check("rst_ready", {31'd0, req_ready_out}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid_out}, 32'd0);
    check("rst_rdata", resp_rdata_out, 32'd0);
    check("rst_err", {31'd0, resp_err_out}, 32'd0);
    check("rst_wr_en", {31'd0, wr_en_out}, 32'd0);
    check("rst_wr_addr", wr_addr_out, 32'd0);
    nrst_in = 1'b1;
    @(negedge clkin);

    // Directed sequence from the test plan.
    issue(1'b0, 3'b000, 32'h4,  32'h0);          // LB  -> FFFFFFF0
    issue(1'b0, 3'b100, 32'h7,  32'h0);          // LBU -> 00000080
    issue(1'b0, 3'b001, 32'h6,  32'h0);          // LH  -> FFFF8070
    issue(1'b0, 3'b101, 32'h4,  32'h0);          // LHU -> 000060F0
    issue(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);  // SW
    issue(1'b1, 3'b000, 32'h11, 32'h0000_00AB);  // SB
    issue(1'b1, 3'b001, 32'h12, 32'h0000_1234);  // SH
    repeat (4) @(negedge clkin);
    check("word4_readback", dmem[4], 32'h1234_ABEF);
    issue(1'b0, 3'b010, 32'h10, 32'h0);          // LW aligned
    issue(1'b0, 3'b010, 32'h13, 32'h0);          // LW misaligned
    issue(1'b1, 3'b100, 32'h10, 32'h5555_5555);  // invalid store funct3
    issue(1'b0, 3'b011, 32'h0,  32'h0);          // invalid load funct3

    // Reset asserted during the WRITE cycle of an SB aborts it.
    repeat (4) @(negedge clkin);
    saved = dmem[8];
    req_valid_in = 1'b1; req_we_in = 1'b1; req_funct3_in = 3'b000;
    req_addr_in = 32'h21; req_wdata_in = 32'h0000_00CD;
    @(posedge clkin); #1;
    req_valid_in = 1'b0;
    @(posedge clkin); #1;
    nrst_in = 1'b0;
    #1;
    check("abort_wr_en", {31'd0, wr_en_out}, 32'd0);
    check("abort_resp_valid", {31'd0, resp_valid_out}, 32'd0);
    @(negedge clkin);
    @(negedge clkin);
    nrst_in = 1'b1;
    @(posedge clkin); #1;
    check("abort_ready_after", {31'd0, req_ready_out}, 32'd1);
    check("abort_mem_unchanged", dmem[8], saved);
    @(negedge clkin);
    issue(1'b0, 3'b010, 32'h20, 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      issue(1'($urandom), 3'($urandom), 32'($urandom_range(0, 255)), $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clkin);
    end

    repeat (6) @(negedge clkin);
    check("resp_q_drained", resp_q.size(), 32'd0);
    check("wr_q_drained", wr_q.size(), 32'd0);
    for (int i = 0; i < 64; i++) check("final_mem", dmem[i], ref_mem[i]);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
